// File: rtl/display_pkg.sv
// Shared seven-segment constants for display blocks: active-low patterns,
// bit order {g,f,e,d,c,b,a}.
package display_pkg;

  localparam int BCD_W = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;

endpackage

// File: rtl/bcd_display_scanner_if.sv
// Display-side bundle of the BCD scanner: digit/dp inputs and registered
// segment, anode and frame outputs. There is no back-pressure: inputs are
// sampled level-wise every clock and outputs are valid every clock.
interface bcd_display_scanner_if #(
  parameter int NUM_DIGITS = 2
);

  logic                      enable;
  logic [4*NUM_DIGITS-1:0]   digits_in;
  logic [NUM_DIGITS-1:0]     dp_in;
  logic [6:0]                seg_n;
  logic                      dp_n;
  logic [NUM_DIGITS-1:0]     an_n;
  logic                      frame_done;

  modport master (
    output enable, digits_in, dp_in,
    input  seg_n, dp_n, an_n, frame_done
  );

  modport slave (
    input  enable, digits_in, dp_in,
    output seg_n, dp_n, an_n, frame_done
  );

endinterface

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low seven-segment decoder; codes 10-15 show
// a dash.
module bcd_to_7seg
  import display_pkg::*;
(
  input  logic [BCD_W-1:0] i_bcd,
  output logic [6:0]       o_seg_n
);

  always_comb begin
    o_seg_n = SEG_DASH;
    case (i_bcd)
      4'd0:    o_seg_n = SEG_0;
      4'd1:    o_seg_n = SEG_1;
      4'd2:    o_seg_n = SEG_2;
      4'd3:    o_seg_n = SEG_3;
      4'd4:    o_seg_n = SEG_4;
      4'd5:    o_seg_n = SEG_5;
      4'd6:    o_seg_n = SEG_6;
      4'd7:    o_seg_n = SEG_7;
      4'd8:    o_seg_n = SEG_8;
      4'd9:    o_seg_n = SEG_9;
      default: o_seg_n = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed BCD display scanner with frame-synchronous shadow capture.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
module bcd_display_scanner
  import display_pkg::*;
#(
  parameter int NUM_DIGITS  = 2,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  bcd_display_scanner_if.slave  bus
);

  localparam int PRESC_W = $clog2(REFRESH_DIV);
  localparam int IDX_W   = $clog2(NUM_DIGITS);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  logic [PRESC_W-1:0]          r_presc;
  logic [IDX_W-1:0]            r_idx;
  logic [BCD_W*NUM_DIGITS-1:0] r_shadow_digits;
  logic [NUM_DIGITS-1:0]       r_shadow_dp;
  logic [6:0]                  r_seg_n;
  logic                        r_dp_n;
  logic [NUM_DIGITS-1:0]       r_an_n;
  logic                        r_frame_done;

  logic                        w_tick;
  logic                        w_wrap;
  logic [BCD_W-1:0]            w_digit_arr [NUM_DIGITS];
  logic [BCD_W-1:0]            w_nibble;
  logic                        w_dp;
  logic [NUM_DIGITS-1:0]       w_an_n;
  logic [6:0]                  w_seg_dec;
  logic [6:0]                  w_seg_next;
  logic                        w_dp_next;

  assign w_tick = bus.enable && (r_presc == PRESC_LAST);
  assign w_wrap = w_tick && (r_idx == IDX_LAST);

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    assign w_digit_arr[g] = r_shadow_digits[BCD_W*g +: BCD_W];
  end

  // Digit mux and one-cold anode pattern share the same index compare.
  always_comb begin
    w_nibble = '0;
    w_dp     = 1'b0;
    w_an_n   = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_nibble  = w_digit_arr[k];
        w_dp      = r_shadow_dp[k];
        w_an_n[k] = 1'b0;
      end
    end
  end

  bcd_to_7seg u_dec (
    .i_bcd   (w_nibble),
    .o_seg_n (w_seg_dec)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic [IDX_W-1:0] w_msd;
  logic             w_blank;

  // Highest non-zero shadow digit; an all-zero value leaves digit 0 lit.
  always_comb begin
    w_msd = '0;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      if (w_digit_arr[k] != 4'd0) begin
        w_msd = IDX_W'(k);
      end
    end
  end

  assign w_blank    = (r_idx > w_msd);
  assign w_seg_next = w_blank ? SEG_BLANK : w_seg_dec;
  assign w_dp_next  = w_blank | ~w_dp;
`else
  assign w_seg_next = w_seg_dec;
  assign w_dp_next  = ~w_dp;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc         <= '0;
      r_idx           <= '0;
      r_shadow_digits <= '0;
      r_shadow_dp     <= '0;
      r_seg_n         <= SEG_BLANK;
      r_dp_n          <= 1'b1;
      r_an_n          <= '1;
      r_frame_done    <= 1'b0;
    end else if (!bus.enable) begin
      // Idle: track inputs so the first enabled frame shows current data.
      r_presc         <= '0;
      r_idx           <= '0;
      r_shadow_digits <= bus.digits_in;
      r_shadow_dp     <= bus.dp_in;
      r_seg_n         <= SEG_BLANK;
      r_dp_n          <= 1'b1;
      r_an_n          <= '1;
      r_frame_done    <= 1'b0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PRESC_W'(1);
      if (w_tick) begin
        r_idx <= w_wrap ? '0 : r_idx + IDX_W'(1);
      end
      if (w_wrap) begin
        r_shadow_digits <= bus.digits_in;
        r_shadow_dp     <= bus.dp_in;
      end
      r_seg_n      <= w_seg_next;
      r_dp_n       <= w_dp_next;
      r_an_n       <= w_an_n;
      r_frame_done <= w_wrap;
    end
  end

  assign bus.seg_n      = r_seg_n;
  assign bus.dp_n       = r_dp_n;
  assign bus.an_n       = r_an_n;
  assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner (NUM_DIGITS=2, REFRESH_DIV=4);
// expectations adapt to LEADING_ZERO_BLANK_EN.
module tb_bcd_display_scanner;

  localparam int ND = 2;
  localparam int RD = 4;

  localparam logic [6:0] S_BLANK = 7'h7F;
  localparam logic [6:0] S_DASH  = 7'h3F;
  localparam logic [6:0] S_0     = 7'h40;
  localparam logic [6:0] S_1     = 7'h79;
  localparam logic [6:0] S_2     = 7'h24;
  localparam logic [6:0] S_3     = 7'h30;
  localparam logic [6:0] S_4     = 7'h19;
  localparam logic [6:0] S_5     = 7'h12;
  localparam logic [6:0] S_7     = 7'h78;
  localparam logic [6:0] S_9     = 7'h10;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] S_LZ    = 7'h7F;
`else
  localparam logic [6:0] S_LZ    = 7'h40;
`endif

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  logic [10:0] exp_q[$];
  logic [10:0] got;
  logic [10:0] exp_v;

  bcd_display_scanner_if #(.NUM_DIGITS(ND)) bus ();

  bcd_display_scanner #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed tuple layout: {an_n[1:0], seg_n[6:0], dp_n, frame_done}
  function automatic logic [10:0] tup(input logic [1:0] an, input logic [6:0] seg,
                                      input logic dp, input logic fd);
    return {an, seg, dp, fd};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic start_scan(input logic [7:0] d, input logic [1:0] p);
    @(negedge clk);
    bus.enable    = 1'b0;
    bus.digits_in = d;
    bus.dp_in     = p;
    @(negedge clk);
    bus.enable    = 1'b1;
  endtask

  task automatic push_frame(input logic [6:0] s0, input logic dp0,
                            input logic [6:0] s1, input logic dp1);
    for (int i = 0; i < RD; i++) exp_q.push_back(tup(2'b10, s0, dp0, 1'b0));
    for (int i = 0; i < RD; i++) exp_q.push_back(tup(2'b01, s1, dp1, i == RD - 1));
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #1;
    got = {bus.an_n, bus.seg_n, bus.dp_n, bus.frame_done};
    vectors++;
    if (got !== tup(2'b11, S_BLANK, 1'b1, 1'b0)) begin
      miscompares++;
      $display("FAIL reset_async: got %b required %b", got, tup(2'b11, S_BLANK, 1'b1, 1'b0));
    end
    bus.enable = 1'b1;
    repeat (2) @(negedge clk);
    got = {bus.an_n, bus.seg_n, bus.dp_n, bus.frame_done};
    vectors++;
    if (got !== tup(2'b11, S_BLANK, 1'b1, 1'b0)) begin
      miscompares++;
      $display("FAIL reset_held: got %b required %b", got, tup(2'b11, S_BLANK, 1'b1, 1'b0));
    end
    bus.enable = 1'b0;
    reset      = 1'b0;
  endtask

  task automatic test_scan_digits();
    start_scan(8'h93, 2'b00);
    push_frame(S_3, 1'b1, S_9, 1'b1);
    push_frame(S_3, 1'b1, S_9, 1'b1);
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      got   = {bus.an_n, bus.seg_n, bus.dp_n, bus.frame_done};
      exp_v = exp_q.pop_front();
      vectors++;
      if (got !== exp_v) begin
        miscompares++;
        $display("FAIL scan_93 cyc %0d: got %b required %b", c, got, exp_v);
      end
    end
  endtask

  task automatic test_no_tearing();
    start_scan(8'h93, 2'b00);
    push_frame(S_3, 1'b1, S_9, 1'b1);
    push_frame(S_1, 1'b1, S_2, 1'b1);
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      got   = {bus.an_n, bus.seg_n, bus.dp_n, bus.frame_done};
      exp_v = exp_q.pop_front();
      vectors++;
      if (got !== exp_v) begin
        miscompares++;
        $display("FAIL no_tearing cyc %0d: got %b required %b", c, got, exp_v);
      end
      if (c == 5) bus.digits_in = 8'h21;
    end
  endtask

  task automatic test_dash_dp();
    start_scan(8'h7C, 2'b01);
    push_frame(S_DASH, 1'b0, S_7, 1'b1);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      got   = {bus.an_n, bus.seg_n, bus.dp_n, bus.frame_done};
      exp_v = exp_q.pop_front();
      vectors++;
      if (got !== exp_v) begin
        miscompares++;
        $display("FAIL dash_dp cyc %0d: got %b required %b", c, got, exp_v);
      end
    end
  endtask

  task automatic test_enable_drop();
    start_scan(8'h93, 2'b00);
    exp_q.push_back(tup(2'b10, S_3, 1'b1, 1'b0));
    exp_q.push_back(tup(2'b10, S_3, 1'b1, 1'b0));
    exp_q.push_back(tup(2'b11, S_BLANK, 1'b1, 1'b0));
    exp_q.push_back(tup(2'b11, S_BLANK, 1'b1, 1'b0));
    push_frame(S_5, 1'b1, S_4, 1'b1);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      got   = {bus.an_n, bus.seg_n, bus.dp_n, bus.frame_done};
      exp_v = exp_q.pop_front();
      vectors++;
      if (got !== exp_v) begin
        miscompares++;
        $display("FAIL enable_drop cyc %0d: got %b required %b", c, got, exp_v);
      end
      if (c == 2) bus.enable = 1'b0;
      if (c == 3) bus.digits_in = 8'h45;
      if (c == 4) begin
        bus.enable    = 1'b1;
        bus.digits_in = 8'h11;
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    start_scan(8'h93, 2'b00);
    repeat (8) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    got = {bus.an_n, bus.seg_n, bus.dp_n, bus.frame_done};
    vectors++;
    if (got !== tup(2'b11, S_BLANK, 1'b1, 1'b0)) begin
      miscompares++;
      $display("FAIL reset_mid_scan: got %b required %b", got, tup(2'b11, S_BLANK, 1'b1, 1'b0));
    end
    @(negedge clk);
    reset = 1'b0;
    push_frame(S_0, 1'b1, S_LZ, 1'b1);
    exp_q.push_back(tup(2'b10, S_3, 1'b1, 1'b0));
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      got   = {bus.an_n, bus.seg_n, bus.dp_n, bus.frame_done};
      exp_v = exp_q.pop_front();
      vectors++;
      if (got !== exp_v) begin
        miscompares++;
        $display("FAIL restart_after_reset cyc %0d: got %b required %b", c, got, exp_v);
      end
    end
  endtask

  task automatic test_leading_zero();
    start_scan(8'h05, 2'b00);
    push_frame(S_5, 1'b1, S_LZ, 1'b1);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      got   = {bus.an_n, bus.seg_n, bus.dp_n, bus.frame_done};
      exp_v = exp_q.pop_front();
      vectors++;
      if (got !== exp_v) begin
        miscompares++;
        $display("FAIL lzb_05 cyc %0d: got %b required %b", c, got, exp_v);
      end
    end
    start_scan(8'h00, 2'b00);
    push_frame(S_0, 1'b1, S_LZ, 1'b1);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      got   = {bus.an_n, bus.seg_n, bus.dp_n, bus.frame_done};
      exp_v = exp_q.pop_front();
      vectors++;
      if (got !== exp_v) begin
        miscompares++;
        $display("FAIL lzb_00 cyc %0d: got %b required %b", c, got, exp_v);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    vectors       = 0;
    miscompares   = 0;
    reset         = 1'b1;
    bus.enable    = 1'b0;
    bus.digits_in = 8'h93;
    bus.dp_in     = 2'b00;

    test_reset();
    test_scan_digits();
    test_no_tearing();
    test_dash_dp();
    test_enable_drop();
    test_reset_mid_scan();
    test_leading_zero();

    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL exp_q_leftover: got %0d entries required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bcd_display_scanner.md
BCD_DISPLAY_SCANNER -- requirements
Module: bcd_display_scanner

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 2, number of BCD digits scanned (legal 2..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 50000, clk cycles each digit is shown (legal >= 2).
REQ-003 SHALL have port clk  input  1  single clock; all state on posedge clk.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  scan enable; low blanks the display.
REQ-006 SHALL have port digits_in  input  4*NUM_DIGITS  BCD digits; nibble k is digit k, digit 0 least significant.
REQ-007 SHALL have port dp_in  input  NUM_DIGITS  decimal point per digit, active-high.
REQ-008 SHALL have port seg_n  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-009 SHALL have port dp_n  output  1  decimal point of the active digit, active-low, registered.
REQ-010 SHALL have port an_n  output  NUM_DIGITS  digit enables, active-low, one-cold, registered.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse when the scan wraps to digit 0.

Function
REQ-012 SHALL run prescaler 0..REFRESH_DIV-1 while enable=1; tick = (prescaler==REFRESH_DIV-1); prescaler wraps to 0 on tick.
REQ-013 SHALL advance digit index on tick, NUM_DIGITS-1 wraps to 0.
REQ-014 SHALL, on the tick that wraps the index to 0, load shadow register from digits_in/dp_in and pulse frame_done for that cycle.
REQ-015 SHALL drive seg_n, dp_n and an_n from shadow and index with exactly one cycle latency; all three change on the same edge.
REQ-016 SHALL keep changes to digits_in/dp_in invisible until the next shadow load (no mid-frame tearing).
REQ-017 SHALL decode 0-9 as standard active-low patterns (0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10).
REQ-018 SHALL decode nibbles 10-15 as dash, seg_n=7'h3F, with dp_n unaffected.
REQ-019 SHALL, while enable=0, hold prescaler and index at 0, reload shadow every cycle, and register an_n all ones, seg_n=7'h7F, dp_n=1, frame_done=0.
REQ-020 SHALL, on enable rising, show digit 0 from the next edge, with the shadow value captured on the last enable=0 cycle.
REQ-021 SHALL keep exactly one an_n bit low in every enabled cycle after the first.

Reset
REQ-022 SHALL, on reset, immediately clear prescaler, index, shadow and frame_done, and set an_n all ones, seg_n=7'h7F, dp_n=1, independent of clk.
REQ-023 SHALL, after reset deasserts mid-scan, restart from digit 0 with a full REFRESH_DIV period.

Configuration
REQ-024 SHALL, with LEADING_ZERO_BLANK_EN defined, blank (seg_n=7'h7F, dp_n=1, an_n still driven) every digit above the most significant non-zero shadow digit; digit 0 is never blanked.
REQ-025 SHALL, without LEADING_ZERO_BLANK_EN, display all digits including leading zeros; no blanking logic present.

Structure
REQ-026 SHALL place segment constants (SEG_BLANK=7'h7F, SEG_DASH=7'h3F, digit patterns 0-9) in shared package display_pkg.
REQ-027 SHALL instantiate one combinational sub-module bcd_to_7seg (4-bit BCD in, 7-bit active-low seg out) for decoding.

Verification (NUM_DIGITS=2, REFRESH_DIV=4)
REQ-028 SHALL cover: reset asserted mid-scan -> same-cycle an_n=2'b11, seg_n=7'h7F, frame_done=0.
REQ-029 SHALL cover: digits_in=8'h93, enable=1 -> an_n=2'b10/seg_n=7'h30 for 4 cycles, then an_n=2'b01/seg_n=7'h10 for 4 cycles, repeating; frame_done pulses every 8 cycles.
REQ-030 SHALL cover: digits_in changed 8'h93->8'h21 while digit 1 shown -> 9 stays until after frame_done, then 1 (7'h79) and 2 (7'h24).
REQ-031 SHALL cover: digits_in=8'h7C, dp_in=2'b01 -> digit 0 seg_n=7'h3F, dp_n=0; digit 1 seg_n=7'h78, dp_n=1.
REQ-032 SHALL cover: enable dropped mid-digit -> blank on next edge; re-raised -> digit 0 shown on next edge, full 4-cycle period.
REQ-033 SHALL cover: digits_in=8'h05 -> digit 1 seg_n=7'h7F with LEADING_ZERO_BLANK_EN, 7'h40 without; 8'h00 -> digit 0 shows 7'h40 in both builds.
